// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and result bus of the sequential binary-to-BCD converter
//
// Signals:
//   CE     clock enable; the converter advances only on CLK edges with CE=1
//   START  conversion request, sampled on CE edges
//   IN     binary value, captured when START is accepted
//   BUSY   conversion in progress
//   DONE   one-CLK pulse when Q/OVF are updated
//   OVF    result did not fit in OUT_DECADES decades
//   Q      BCD result, decade n in Q[4n+3:4n]
// Modports: master drives CE/START/IN, slave (the converter) drives BUSY/DONE/OVF/Q.
interface bin_to_bcd_seq_if #(
    parameter int IN_BITS_NUM = 17,
    parameter int OUT_DECADES = 6
);
    localparam int OUT_BITS_NUM = OUT_DECADES * 4;

    logic                    CE;
    logic                    START;
    logic [IN_BITS_NUM-1:0]  IN;
    logic                    BUSY;
    logic                    DONE;
    logic                    OVF;
    logic [OUT_BITS_NUM-1:0] Q;

    modport master (output CE, START, IN, input BUSY, DONE, OVF, Q);
    modport slave  (input CE, START, IN, output BUSY, DONE, OVF, Q);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter
//
// Ports:
//   CLK  system clock
//   CLR  synchronous active-high reset, has priority over CE
//   bus  bin_to_bcd_seq_if.slave: CE, START, IN in; BUSY, DONE, OVF, Q out
// Optional build macro BIN_TO_BCD_SEQ_LZ_BLANK_EN: leading zero decades
// (never decade 0, never a saturated result) are committed as 4'hF.
module bin_to_bcd_seq #(
    parameter int IN_BITS_NUM  = 17,
    parameter int OUT_DECADES  = 6,
    parameter int OUT_BITS_NUM = OUT_DECADES * 4
) (
    input  logic               CLK,
    input  logic               CLR,
    bin_to_bcd_seq_if.slave    bus
);
    localparam int CNT_W = $clog2(IN_BITS_NUM + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                  state, state_n;
    logic [IN_BITS_NUM-1:0]  bin_sr, bin_n;
    logic [OUT_BITS_NUM-1:0] acc, acc_n, acc_adj, commit_val;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    sticky, sticky_n;
    logic [OUT_BITS_NUM-1:0] q_r, q_n;
    logic                    ovf_r, ovf_n;
    logic                    busy_r, busy_n;
    logic                    done_r, done_n;

    // Add-3 correction applied before each shift to every decade >= 5.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < OUT_DECADES; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Value written to Q at commit: saturated 9s on overflow, otherwise the
    // accumulator (optionally with leading zero decades blanked).
    always_comb begin
        commit_val = acc;
        if (sticky) begin
            for (int i = 0; i < OUT_DECADES; i++)
                commit_val[4*i +: 4] = 4'h9;
        end
`ifdef BIN_TO_BCD_SEQ_LZ_BLANK_EN
        else begin
            logic seen_nz;
            seen_nz = 1'b0;
            for (int i = OUT_DECADES - 1; i >= 1; i--) begin
                if (acc[4*i +: 4] != 4'h0)
                    seen_nz = 1'b1;
                if (!seen_nz)
                    commit_val[4*i +: 4] = 4'hF;
            end
        end
`else
        else begin
            commit_val = acc;
        end
`endif
    end

    always_comb begin
        state_n  = state;
        bin_n    = bin_sr;
        acc_n    = acc;
        cnt_n    = cnt;
        sticky_n = sticky;
        q_n      = q_r;
        ovf_n    = ovf_r;
        busy_n   = busy_r;
        done_n   = 1'b0;            // DONE lasts exactly one CLK, independent of CE
        if (bus.CE) begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        bin_n    = bus.IN;
                        acc_n    = '0;
                        sticky_n = 1'b0;
                        cnt_n    = CNT_W'(IN_BITS_NUM);
                        busy_n   = 1'b1;
                        state_n  = SHIFT;
                    end
                end
                SHIFT: begin
                    // The bit leaving the top decade is lost: record it as overflow.
                    {acc_n, bin_n} = {acc_adj[OUT_BITS_NUM-2:0], bin_sr, 1'b0};
                    sticky_n       = sticky | acc_adj[OUT_BITS_NUM-1];
                    cnt_n          = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state_n = COMMIT;
                end
                COMMIT: begin
                    q_n     = commit_val;
                    ovf_n   = sticky;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= IDLE;
            bin_sr <= '0;
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            q_r    <= '0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            bin_sr <= bin_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            sticky <= sticky_n;
            q_r    <= q_n;
            ovf_r  <= ovf_n;
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    assign bus.Q    = q_r;
    assign bus.OVF  = ovf_r;
    assign bus.BUSY = busy_r;
    assign bus.DONE = done_r;
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter built on the shift-and-add-3 (double-dabble) algorithm. It replaces the per-decade divide/modulo converter. It is sized for wide countdown values with up to any number of decades, uses a start/busy/done handshake and flags overflow. It sits between the countdown counter and the 7-segment digit multiplexer, and its conversion is paced by the shared prescaler CE.

Parameters:
IN_BITS_NUM, 17, width of binary input (17 bits covers 0..131071).
OUT_DECADES, 6, number of BCD decades produced (at least 1).
OUT_BITS_NUM, OUT_DECADES*4, width of BCD output bus (derived; do not override).

Ports:
CLK  in  1  system clock; the only clock.
CLR  in  1  synchronous active-high reset.
CE  in  1  clock enable; the FSM advances only on CLK edges with CE=1.
START  in  1  conversion request, sampled on CLK edges with CE=1.
IN  in  IN_BITS_NUM  binary value, captured only when START is accepted.
BUSY  out  1  conversion in progress.
DONE  out  1  one-CLK pulse when Q/OVF are updated.
OVF  out  1  result did not fit in OUT_DECADES decades.
Q  out  OUT_BITS_NUM  BCD result; decade 0 in Q[3:0], decade n in Q[4n+3:4n].

Behaviour:
- Interface: one clock; reset is synchronous and active-high. CLR has priority over CE.
- Reset values: Q=0, BUSY=0, DONE=0, OVF=0, FSM=IDLE, internal shift register and counter = 0.
- FSM has three states: IDLE, SHIFT and COMMIT.
- IDLE: on a CE=1 edge with START=1, load IN into the binary shift register, clear the BCD accumulator and the overflow flag, load counter = IN_BITS_NUM, set BUSY=1, go to SHIFT.
- SHIFT: on each CE=1 edge:
  - Add 3 to every accumulator decade whose value is 5 or more.
  - Shift the {accumulator, binary} register left by 1.
  - Decrement the counter.
  - Go to COMMIT when the counter reaches 0.
- COMMIT: on a CE=1 edge, copy the accumulator to Q and the sticky overflow flag to OVF, set DONE=1, set BUSY=0, go to IDLE.
- Latency: if START is accepted at CE edge k, the shifts occur at CE edges k+1..k+IN_BITS_NUM and the commit at CE edge k+IN_BITS_NUM+1. With CE tied high, DONE is high during cycle IN_BITS_NUM+2 after START.
- DONE is cleared on the next CLK edge regardless of CE.
- Q and OVF hold their value between commits.
- Overflow detection: the sticky overflow flag sets if a 1 is shifted out of the top bit of the top decade on any shift.
  - When OVF=1, Q is committed saturated to all decades = 9.
  - If 10^OUT_DECADES exceeds 2^IN_BITS_NUM-1, OVF can never set.
- START while BUSY=1 is ignored; the in-flight conversion is not disturbed.
- START in the same cycle DONE is high is accepted, because the FSM is already in IDLE.
- IN changes after acceptance have no effect.
- CE=0 freezes the FSM, counter and datapath; BUSY keeps its value.
- CLR mid-conversion aborts the conversion: all outputs return to reset values and no DONE is issued.
- IN=0 gives Q=0, OVF=0 after the full latency (no early exit).

Optional Feature:
- Macro: BIN_TO_BCD_SEQ_LZ_BLANK_EN.
- Defined: at COMMIT, every decade above the most significant non-zero decade is written as 4'hF, which the segment decoder treats as blank. Decade 0 is never blanked, so a value of 0 shows "0". Saturated overflow results are not blanked.
- Undefined: leading decades are output as 4'h0; no 4'hF codes are ever produced.

Test Plan:
- Defaults, CE=1, START with IN=99999 -> BUSY high for 18 cycles, DONE pulses once, Q=24'h099999, OVF=0 (with LZ_BLANK_EN defined: Q=24'hF99999).
- Defaults, IN=131071 -> Q=24'h131071, OVF=0. IN=0 -> Q=24'h000000 (with macro: 24'hFFFFF0).
- IN_BITS_NUM=8, OUT_DECADES=2, IN=255 -> OVF=1, Q=8'h99. Then IN=42 -> OVF=0, Q=8'h42.
- CE pulsed every 4th CLK, IN=12345 -> DONE appears after exactly 18 CE pulses, Q=24'h012345; a second START while BUSY with IN=1 is ignored.
- CLR asserted at shift 5 of a conversion of IN=777 -> next cycle Q=0, BUSY=0, no DONE. A new START with IN=777 -> Q=24'h000777.
- Back-to-back: START held high with IN=10 then IN=20 -> two DONE pulses 19 cycles apart, Q=24'h000010 then 24'h000020.
